// File: rtl/fabric_pkg.sv
// Shared fabric definitions: elaboration error codes and width helpers.
package fabric_pkg;

   localparam string ERR_FIFO_DEPTH      = "COMP_FIFO_DEPTH";
   localparam string ERR_FIFO_DATA_WIDTH = "COMP_FIFO_DATA_WIDTH";

   typedef enum logic {
      MODE_FIFO   = 1'b0,
      MODE_BYPASS = 1'b1
   } fifo_mode_e;

   // Width needed to hold an occupancy value in 0..depth.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fabric_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port, no reset.
module fabric_fifo_mem #(
   parameter int DEPTH  = 2,
   parameter int WIDTH  = 1,
   parameter int ADDR_W = 1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fabric_fifo.sv
// Registered-count FIFO with optional pass-through bypass when empty.
module fabric_fifo
   import fabric_pkg::*;
#(
   parameter  int DEPTH         = 2,
   parameter  int DATA_WIDTH    = 32,
   parameter  int TAG_WIDTH     = 0,
   localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH,
   localparam int SAFE_PW       = (PAYLOAD_WIDTH > 1) ? PAYLOAD_WIDTH : 1,
   localparam int CNT_W         = cnt_width(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SAFE_PW-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SAFE_PW-1:0] out_data,
   input  logic               cfg_data,
   output logic [CNT_W-1:0]   count
);

   if (DEPTH < 1) begin : g_bad_depth
      $fatal(1, "%s", ERR_FIFO_DEPTH);
   end
   if (DATA_WIDTH < 1) begin : g_bad_width
      $fatal(1, "%s", ERR_FIFO_DATA_WIDTH);
   end

   localparam int PTR_W = ptr_width(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   cnt_q;
   logic [SAFE_PW-1:0] rd_word;
   fifo_mode_e         mode;
   logic               fifo_in_ready;
   logic               fifo_out_valid;
   logic               push;
   logic               pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Bypass keys off the registered count, so a late enable waits for the drain.
   assign mode = (cfg_data && (cnt_q == '0)) ? MODE_BYPASS : MODE_FIFO;

   assign fifo_in_ready  = (cnt_q < FULL_CNT);
   assign fifo_out_valid = (cnt_q != '0);
   assign push = (mode == MODE_FIFO) && in_valid && fifo_in_ready;
   assign pop  = (mode == MODE_FIFO) && fifo_out_valid && out_ready;

   always_comb begin
      in_ready  = fifo_in_ready;
      out_valid = fifo_out_valid;
      out_data  = rd_word;
      if (mode == MODE_BYPASS) begin
         in_ready  = out_ready;
         out_valid = in_valid;
         out_data  = in_data;
      end
   end

   assign count = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   fabric_fifo_mem #(
      .DEPTH  (DEPTH),
      .WIDTH  (SAFE_PW),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_word)
   );

endmodule

// File: tb/tb_fabric_fifo.sv
// Scoreboard bench for fabric_fifo at DEPTH 4, 3 and 2 with a 4-bit tag.
module tb_fabric_fifo;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv   [NI];
   logic        ir   [NI];
   logic        ov   [NI];
   logic        ordy [NI];
   logic        bp   [NI];
   logic [19:0] id   [NI];
   logic [19:0] od   [NI];
   logic [2:0]  cnt  [NI];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int D = (g == 0) ? 4 : (g == 1) ? 3 : 2;
      logic [$clog2(D+1)-1:0] c;
      logic [19:0] sb [$];

      fabric_fifo #(
         .DEPTH      (D),
         .DATA_WIDTH (16),
         .TAG_WIDTH  (4)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .in_data   (id[g]),
         .out_valid (ov[g]),
         .out_ready (ordy[g]),
         .out_data  (od[g]),
         .cfg_data  (bp[g]),
         .count     (c)
      );

      assign cnt[g] = 3'(c);

      // Handshakes seen here complete on the following rising edge.
      always @(negedge clk) begin
         if (rst) begin
            sb.delete();
         end else begin
            if (iv[g] && ir[g]) sb.push_back(id[g]);
            if (ov[g] && ordy[g]) begin
               if (sb.size() == 0)
                  chk($sformatf("sb_underflow%0d", g), 32'(sb.size() != 0), 32'd1);
               else
                  chk($sformatf("out_data%0d", g), 32'(od[g]), 32'(sb.pop_front()));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         iv[i] = 1'b0; ordy[i] = 1'b0; bp[i] = 1'b0; id[i] = '0;
      end
      tick(); tick();
      rst = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_count%0d", i),    32'(cnt[i]), 32'd0);
         chk($sformatf("rst_out_valid%0d", i), 32'(ov[i]), 32'd0);
         chk($sformatf("rst_in_ready%0d", i),  32'(ir[i]), 32'd1);
      end

      // DEPTH=4: fill, full refusal, drain in order
      for (int k = 0; k < 4; k++) begin
         iv[0] = 1'b1; id[0] = 20'hA1 + 20'(k);
         tick();
      end
      iv[0] = 1'b0;
      chk("full_count", 32'(cnt[0]), 32'd4);
      chk("full_in_ready", 32'(ir[0]), 32'd0);
      iv[0] = 1'b1; id[0] = 20'hFF; ordy[0] = 1'b1;
      #1;
      chk("full_in_ready_popping", 32'(ir[0]), 32'd0);
      iv[0] = 1'b0;
      repeat (4) tick();
      chk("drain_count", 32'(cnt[0]), 32'd0);
      chk("drain_out_valid", 32'(ov[0]), 32'd0);
      ordy[0] = 1'b0;

      // DEPTH=3: continuous stream, pointer wrap
      ordy[1] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         iv[1] = 1'b1; id[1] = 20'h100 + 20'(k);
         tick();
         chk("stream_count", 32'(cnt[1]), 32'd1);
      end
      iv[1] = 1'b0;
      tick();
      chk("stream_end_count", 32'(cnt[1]), 32'd0);
      ordy[1] = 1'b0;

      // DEPTH=2: full with simultaneous push attempt and pop
      for (int k = 0; k < 2; k++) begin
         iv[2] = 1'b1; id[2] = 20'h21 + 20'(k);
         tick();
      end
      chk("d2_full_count", 32'(cnt[2]), 32'd2);
      id[2] = 20'h33; ordy[2] = 1'b1;
      #1;
      chk("d2_full_in_ready", 32'(ir[2]), 32'd0);
      tick();
      chk("d2_after_pop_count", 32'(cnt[2]), 32'd1);
      iv[2] = 1'b0;
      tick();
      chk("d2_drain_count", 32'(cnt[2]), 32'd0);
      ordy[2] = 1'b0;

      // DEPTH=4: steady state at count 2 with push and pop together
      for (int k = 0; k < 2; k++) begin
         iv[0] = 1'b1; id[0] = 20'h200 + 20'(k);
         tick();
      end
      ordy[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         id[0] = 20'h210 + 20'(k);
         tick();
         chk("steady_count", 32'(cnt[0]), 32'd2);
      end
      iv[0] = 1'b0;
      tick(); tick();
      chk("steady_drain_count", 32'(cnt[0]), 32'd0);

      // Bypass while empty: same-cycle pass-through
      bp[0] = 1'b1; iv[0] = 1'b1; id[0] = 20'h5DEAD;
      #1;
      chk("byp_out_data", 32'(od[0]), 32'h5DEAD);
      chk("byp_out_valid", 32'(ov[0]), 32'd1);
      chk("byp_count", 32'(cnt[0]), 32'd0);
      ordy[0] = 1'b0;
      #1;
      chk("byp_in_ready_follows", 32'(ir[0]), 32'd0);
      ordy[0] = 1'b1;
      tick();
      chk("byp_count_after", 32'(cnt[0]), 32'd0);
      iv[0] = 1'b0; bp[0] = 1'b0; ordy[0] = 1'b0;

      // Bypass enabled with data held: drain first, then pass-through
      for (int k = 0; k < 2; k++) begin
         iv[0] = 1'b1; id[0] = 20'h3C1 + 20'(k);
         tick();
      end
      iv[0] = 1'b0; bp[0] = 1'b1;
      #1;
      chk("late_byp_out_data", 32'(od[0]), 32'h3C1);
      chk("late_byp_in_ready", 32'(ir[0]), 32'd1);
      ordy[0] = 1'b1;
      tick(); tick();
      chk("late_byp_drained", 32'(cnt[0]), 32'd0);
      iv[0] = 1'b1; id[0] = 20'h7BEEF;
      #1;
      chk("late_byp_pass", 32'(od[0]), 32'h7BEEF);
      tick();
      chk("late_byp_count", 32'(cnt[0]), 32'd0);
      iv[0] = 1'b0; bp[0] = 1'b0; ordy[0] = 1'b0;

      // Reset mid-operation discards contents
      for (int k = 0; k < 3; k++) begin
         iv[0] = 1'b1; id[0] = 20'h400 + 20'(k);
         tick();
      end
      iv[0] = 1'b0;
      chk("pre_rst_count", 32'(cnt[0]), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_count", 32'(cnt[0]), 32'd0);
      chk("post_rst_out_valid", 32'(ov[0]), 32'd0);
      chk("post_rst_in_ready", 32'(ir[0]), 32'd1);
      tick();

      chk("sb_left0", 32'(g_dut[0].sb.size()), 32'd0);
      chk("sb_left1", 32'(g_dut[1].sb.size()), 32'd0);
      chk("sb_left2", 32'(g_dut[2].sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
